// File: rtl/bubble_sort_engine.sv
// Paced bubble sort over six 8-bit elements; one compare or one swap per step_tick.
// Outputs are registered and always describe the current state; load/start are honoured only when idle or done.
module bubble_sort_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [47:0] load_data,
    input  logic        start,
    input  logic        step_tick,
    output logic [47:0] array_flat,
    output logic [2:0]  compare_idx1,
    output logic [2:0]  compare_idx2,
    output logic        swap_flag,
    output logic        sorting,
    output logic        done,
    output logic [3:0]  swap_count
);

    typedef enum logic [1:0] {IDLE, COMPARE, SWAP, DONE} state_t;

    localparam logic [47:0] RESET_ARRAY = {8'd25, 8'd250, 8'd100, 8'd150, 8'd50, 8'd200};

    state_t          state, state_nxt;
    logic [5:0][7:0] arr, arr_nxt;
    logic [2:0]      j, j_nxt, j_inc;
    logic [2:0]      pass, pass_nxt;
    logic            pass_swapped, pass_swapped_nxt, swapped_now;
    logic [3:0]      count_nxt;
    logic [2:0]      idx1_nxt, idx2_nxt;
    logic            swap_flag_nxt, sorting_nxt, done_nxt;
    logic            advance;
    logic [7:0]      elem_lo, elem_hi;

    assign j_inc      = j + 3'd1;
    assign elem_lo    = arr[j];
    assign elem_hi    = arr[j_inc];
    assign array_flat = arr;

    always_comb begin
        state_nxt        = state;
        arr_nxt          = arr;
        j_nxt            = j;
        pass_nxt         = pass;
        pass_swapped_nxt = pass_swapped;
        swapped_now      = pass_swapped;
        count_nxt        = swap_count;
        advance          = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (load) begin
                    arr_nxt   = load_data;
                    state_nxt = IDLE;
                    count_nxt = 4'd0;
                end else if (start) begin
                    state_nxt        = COMPARE;
                    j_nxt            = 3'd0;
                    pass_nxt         = 3'd0;
                    pass_swapped_nxt = 1'b0;
                    count_nxt        = 4'd0;
                end
            end
            COMPARE: begin
                // Strict greater-than keeps equal elements in order
                if (step_tick) begin
                    if (elem_lo > elem_hi) state_nxt = SWAP;
                    else                   advance   = 1'b1;
                end
            end
            SWAP: begin
                if (step_tick) begin
                    arr_nxt[j]       = elem_hi;
                    arr_nxt[j_inc]   = elem_lo;
                    pass_swapped_nxt = 1'b1;
                    swapped_now      = 1'b1;
                    count_nxt        = (swap_count == 4'd15) ? swap_count : swap_count + 4'd1;
                    advance          = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (advance) begin
            if ({1'b0, j_inc} < (4'd5 - {1'b0, pass})) begin
                j_nxt     = j_inc;
                state_nxt = COMPARE;
            end else if (!swapped_now || pass == 3'd4) begin
                state_nxt = DONE;
            end else begin
                pass_nxt         = pass + 3'd1;
                j_nxt            = 3'd0;
                pass_swapped_nxt = 1'b0;
                state_nxt        = COMPARE;
            end
        end

        // Status outputs are derived from the next state so they register in step with it
        sorting_nxt   = (state_nxt == COMPARE) || (state_nxt == SWAP);
        swap_flag_nxt = (state_nxt == SWAP);
        done_nxt      = (state_nxt == DONE);
        idx1_nxt      = sorting_nxt ? j_nxt : 3'd0;
        idx2_nxt      = sorting_nxt ? j_nxt + 3'd1 : 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            arr          <= RESET_ARRAY;
            j            <= 3'd0;
            pass         <= 3'd0;
            pass_swapped <= 1'b0;
            swap_count   <= 4'd0;
            compare_idx1 <= 3'd0;
            compare_idx2 <= 3'd1;
            swap_flag    <= 1'b0;
            sorting      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            arr          <= arr_nxt;
            j            <= j_nxt;
            pass         <= pass_nxt;
            pass_swapped <= pass_swapped_nxt;
            swap_count   <= count_nxt;
            compare_idx1 <= idx1_nxt;
            compare_idx2 <= idx2_nxt;
            swap_flag    <= swap_flag_nxt;
            sorting      <= sorting_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Randomized and directed bench for bubble_sort_engine against a bubble-sort event model.
module tb_bubble_sort_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [47:0] load_data;
    logic        start;
    logic        step_tick;
    logic [47:0] array_flat;
    logic [2:0]  compare_idx1;
    logic [2:0]  compare_idx2;
    logic        swap_flag;
    logic        sorting;
    logic        done;
    logic [3:0]  swap_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] DEFAULT_IN  = {8'd25, 8'd250, 8'd100, 8'd150, 8'd50, 8'd200};
    localparam logic [47:0] DEFAULT_OUT = {8'd250, 8'd200, 8'd150, 8'd100, 8'd50, 8'd25};
    localparam logic [47:0] SORTED_IN   = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    localparam logic [47:0] REVERSE_IN  = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    localparam logic [47:0] DUP_IN      = {8'd0, 8'd9, 8'd3, 8'd3, 8'd7, 8'd7};
    localparam logic [47:0] DUP_OUT     = {8'd9, 8'd7, 8'd7, 8'd3, 8'd3, 8'd0};

    // Expected sequence of visible states: (pair index, swap_flag) per tick
    int          exp_j[$];
    bit          exp_sw[$];
    logic [47:0] exp_final;
    int          exp_cnt;
    int          last_ticks;

    bubble_sort_engine dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_data    (load_data),
        .start        (start),
        .step_tick    (step_tick),
        .array_flat   (array_flat),
        .compare_idx1 (compare_idx1),
        .compare_idx2 (compare_idx2),
        .swap_flag    (swap_flag),
        .sorting      (sorting),
        .done         (done),
        .swap_count   (swap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] elem(input logic [47:0] f, input logic [2:0] i);
        return f[{i, 3'b000} +: 8];
    endfunction

    // Classic early-exit bubble sort, recording every compare and swap step
    task automatic model(input logic [47:0] d);
        int a[6];
        int t;
        bit sw;
        exp_j.delete();
        exp_sw.delete();
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) a[i] = int'(d[8*i +: 8]);
        for (int p = 0; p < 5; p++) begin
            sw = 1'b0;
            for (int k = 0; k < 5 - p; k++) begin
                exp_j.push_back(k);
                exp_sw.push_back(1'b0);
                if (a[k] > a[k+1]) begin
                    exp_j.push_back(k);
                    exp_sw.push_back(1'b1);
                    t = a[k]; a[k] = a[k+1]; a[k+1] = t;
                    sw = 1'b1;
                    exp_cnt++;
                end
            end
            if (!sw) break;
        end
        for (int i = 0; i < 6; i++) exp_final[8*i +: 8] = a[i][7:0];
    endtask

    // Entered and left just after a falling edge; d is the array the sort starts from
    task automatic run_sort(input logic [47:0] d, input bit do_load, input int gap_max);
        int n_exp;
        int ticks;
        if (do_load) begin
            load = 1'b1; load_data = d;
            @(negedge clk);
            load = 1'b0;
            check("load_arr", array_flat, d);
            check("load_done", 48'(done), 48'd0);
            check("load_cnt", 48'(swap_count), 48'd0);
        end
        model(d);
        n_exp = exp_j.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ticks = 0;
        while (done !== 1'b1 && ticks < 40) begin
            if (ticks < n_exp) begin
                check("idx1", 48'(compare_idx1), 48'(exp_j[ticks]));
                check("idx2", 48'(compare_idx2), 48'(exp_j[ticks] + 1));
                check("swap_flag", 48'(swap_flag), 48'(exp_sw[ticks]));
                check("sorting", 48'(sorting), 48'd1);
            end else begin
                check("overrun", 48'(ticks), 48'(n_exp));
            end
            if (swap_flag === 1'b1)
                check("swap_gt", 48'(elem(array_flat, compare_idx1) > elem(array_flat, compare_idx2)), 48'd1);
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (ticks < n_exp)
                check("hold_idx", 48'(compare_idx1), 48'(exp_j[ticks]));
            step_tick = 1'b1;
            @(negedge clk);
            step_tick = 1'b0;
            ticks++;
        end
        last_ticks = ticks;
        check("ticks", 48'(ticks), 48'(n_exp));
        check("done", 48'(done), 48'd1);
        check("done_sorting", 48'(sorting), 48'd0);
        check("done_swap_flag", 48'(swap_flag), 48'd0);
        check("done_idx", 48'({compare_idx1, compare_idx2}), 48'({3'd0, 3'd1}));
        check("final_arr", array_flat, exp_final);
        check("swap_count", 48'(swap_count), 48'(exp_cnt));
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        check("done_tick_ignored", 48'({done, sorting}), 48'({1'b1, 1'b0}));
        check("done_arr_hold", array_flat, exp_final);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_arr"}, array_flat, DEFAULT_IN);
        check({tag, "_cnt"}, 48'(swap_count), 48'd0);
        check({tag, "_idx"}, 48'({compare_idx1, compare_idx2}), 48'({3'd0, 3'd1}));
        check({tag, "_flags"}, 48'({swap_flag, sorting, done}), 48'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] rnd;
        reset = 1'b1; load = 1'b0; load_data = '0; start = 1'b0; step_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        check("idle_tick_ignored", 48'({sorting, done}), 48'd0);

        run_sort(DEFAULT_IN, 1'b0, 0);
        check("default_final", array_flat, DEFAULT_OUT);

        run_sort(SORTED_IN, 1'b1, 0);
        check("sorted_ticks", 48'(last_ticks), 48'd5);
        check("sorted_final", array_flat, SORTED_IN);
        check("sorted_cnt", 48'(swap_count), 48'd0);

        run_sort(REVERSE_IN, 1'b1, 1);
        check("reverse_ticks", 48'(last_ticks), 48'd30);
        check("reverse_final", array_flat, SORTED_IN);
        check("reverse_cnt", 48'(swap_count), 48'd15);

        // Restart from DONE without reloading
        run_sort(SORTED_IN, 1'b0, 0);

        run_sort(DUP_IN, 1'b1, 1);
        check("dup_final", array_flat, DUP_OUT);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 6; i++)
                rnd[8*i +: 8] = (n < 5) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            run_sort(rnd, 1'b1, 2);
        end

        // Mid-sort load/start ignored, pacing hold, then reset during SWAP
        load = 1'b1; load_data = REVERSE_IN;
        @(negedge clk);
        load = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load = 1'b1; start = 1'b1; load_data = DUP_IN;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("ignore_arr", array_flat, REVERSE_IN);
        check("ignore_state", 48'({sorting, swap_flag, compare_idx1}), 48'({1'b1, 1'b0, 3'd0}));
        repeat (100) @(negedge clk);
        check("pace_arr", array_flat, REVERSE_IN);
        check("pace_state", 48'({sorting, swap_flag, compare_idx1, compare_idx2}),
              48'({1'b1, 1'b0, 3'd0, 3'd1}));
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        check("enter_swap", 48'({swap_flag, compare_idx1}), 48'({1'b1, 3'd0}));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midreset");

        // Load beats start when both arrive in DONE
        run_sort(DEFAULT_IN, 1'b0, 0);
        load = 1'b1; start = 1'b1; load_data = DUP_IN;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("prio_arr", array_flat, DUP_IN);
        check("prio_flags", 48'({sorting, done, swap_flag}), 48'd0);
        check("prio_cnt", 48'(swap_count), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
